shop_arb_v: RTL

//  Round-robin arbiter/sequencer sharing one shop_v (3-input selectable gate unit) among NUM_REQ requesters.
//  - Each requester presents operands a/b/c and a 2-bit op code; the block grants one requester at a time.
//  - It drives the shared shop_v inputs from registers, captures its output and returns the result tagged with the winner's id.
//  - Sits between client logic and the single shop_v instance; shop_v stays purely combinational outside this block.

---
 rtl/shop_arb_v.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shop_arb_v.sv
// Round-robin arbiter sharing one combinational shop_v unit among NUM_REQ requesters.
// Optional macro SHOP_ARB_PRIO0_EN: requester 0 gets fixed top priority, the rest round-robin.
module shop_arb_v #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_a,
    input  logic [NUM_REQ-1:0]   i_b,
    input  logic [NUM_REQ-1:0]   i_c,
    input  logic [2*NUM_REQ-1:0] i_code,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic                 o_shop_a,
    output logic                 o_shop_b,
    output logic                 o_shop_c,
    output logic [1:0]           o_shop_code,
    input  logic                 i_shop_f,
    output logic                 o_vld,
    output logic [ID_W-1:0]      o_id,
    output logic                 o_f
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W:0]     w_code_lsb;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_any;
    logic               w_grant;

    // Winner search: first eligible request at or above ptr, wrapping.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_elig = i_req;
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
`ifdef SHOP_ARB_PRIO0_EN
        w_elig[0] = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_any && w_elig[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
`ifdef SHOP_ARB_PRIO0_EN
        if (i_req[0]) begin
            w_any = 1'b1;
            w_win = '0;
        end
`endif
    end

    assign w_code_lsb = {w_win, 1'b0};
    assign w_grant    = (r_state == IDLE) && w_any;

`ifdef SHOP_ARB_PRIO0_EN
    // Requester 0 wins by priority, so it must not disturb the rotation of the others.
    assign w_ptr_nxt = (r_win == '0) ? r_ptr :
                       (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
`else
    assign w_ptr_nxt = (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        o_gnt       = '0;
        o_vld       = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset so the grant output is also quiet while reset is held.
                if (w_any && i_rst_n) begin
                    o_gnt[w_win] = 1'b1;
                end
                if (w_any) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = DONE;
            DONE: begin
                o_vld       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_win       <= '0;
            o_shop_a    <= 1'b0;
            o_shop_b    <= 1'b0;
            o_shop_c    <= 1'b0;
            o_shop_code <= 2'b00;
            o_f         <= 1'b0;
            o_id        <= '0;
        end else begin
            if (w_grant) begin
                r_win       <= w_win;
                o_shop_a    <= i_a[w_win];
                o_shop_b    <= i_b[w_win];
                o_shop_c    <= i_c[w_win];
                o_shop_code <= i_code[w_code_lsb +: 2];
            end
            if (r_state == EXEC) begin
                o_f  <= i_shop_f;
                o_id <= ID_W'(r_win);
            end
            if (r_state == DONE) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

endmodule
